// File: rtl/oled_pkg.sv
// Shared types and SSD1306 command constants for the OLED frame streamer.
package oled_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_GAP_C,
        ST_FETCH,
        ST_WAIT,
        ST_PUSH,
        ST_GAP_D,
        ST_DONE
    } oled_stream_state_t;

    localparam logic [7:0] CMD_SET_COL_ADDR  = 8'h21;
    localparam logic [7:0] CMD_SET_PAGE_ADDR = 8'h22;
    localparam logic [7:0] CMD_DISPLAY_OFF   = 8'hAE;
    localparam logic [7:0] CMD_DISPLAY_ON    = 8'hAF;

    localparam int PREAMBLE_LEN = 6;

endpackage

// File: rtl/oled_frame_streamer.sv
// Streams an SSD1306 addressing-window preamble followed by the whole
// framebuffer into the OLED SPI controller's byte buffer.
//
// state   | meaning
// IDLE    | waiting for start
// CMD     | offering preamble byte cmd_idx (dc=0), stalls on out_full
// GAP_C   | one idle cycle so the lagging out_full can catch up
// FETCH   | framebuffer read strobe for byte_idx
// WAIT    | RAM data arrives, captured into the byte register
// PUSH    | offering captured data byte (dc=1), stalls on out_full
// GAP_D   | one idle cycle, then next byte or DONE
// DONE    | one-cycle done pulse
module oled_frame_streamer
    import oled_pkg::*;
#(
    parameter  int PAGES  = 4,
    parameter  int COLS   = 128,
    localparam int NBYTES = PAGES * COLS,
    localparam int AW     = $clog2(NBYTES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          fb_rd_en,
    output logic [AW-1:0] fb_addr,
    input  logic [7:0]    fb_rd_data,
    output logic [7:0]    out_data,
    output logic          out_we,
    output logic          out_dc,
    input  logic          out_full
);

    oled_stream_state_t state_q, state_d;
    logic [2:0]         cmd_idx_q, cmd_idx_d;
    logic [AW-1:0]      byte_idx_q, byte_idx_d;
    logic [7:0]         out_data_q, out_data_d;

    function automatic logic [7:0] preamble_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return CMD_SET_COL_ADDR;
            3'd1:    return 8'h00;
            3'd2:    return 8'(COLS - 1);
            3'd3:    return CMD_SET_PAGE_ADDR;
            3'd4:    return 8'h00;
            3'd5:    return 8'(PAGES - 1);
            default: return 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cmd_idx_q  <= '0;
            byte_idx_q <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cmd_idx_q  <= cmd_idx_d;
            byte_idx_q <= byte_idx_d;
            out_data_q <= out_data_d;
        end
    end

    // out_data_q doubles as the byte register: it is loaded one cycle ahead
    // of every CMD/PUSH so the byte is stable for the whole offer window.
    always_comb begin
        state_d    = state_q;
        cmd_idx_d  = cmd_idx_q;
        byte_idx_d = byte_idx_q;
        out_data_d = out_data_q;
        out_we     = 1'b0;
        fb_rd_en   = 1'b0;
        done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_CMD;
                    cmd_idx_d  = '0;
                    byte_idx_d = '0;
                    out_data_d = preamble_byte(3'd0);
                end
            end
            ST_CMD: begin
                if (!out_full) begin
                    out_we    = 1'b1;
                    cmd_idx_d = cmd_idx_q + 3'd1;
                    state_d   = ST_GAP_C;
                end
            end
            ST_GAP_C: begin
                if (cmd_idx_q < 3'(PREAMBLE_LEN)) begin
                    state_d    = ST_CMD;
                    out_data_d = preamble_byte(cmd_idx_q);
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                fb_rd_en = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                out_data_d = fb_rd_data;
                state_d    = ST_PUSH;
            end
            ST_PUSH: begin
                if (!out_full) begin
                    out_we  = 1'b1;
                    state_d = ST_GAP_D;
                end
            end
            ST_GAP_D: begin
                if (byte_idx_q == AW'(NBYTES - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    byte_idx_d = byte_idx_q + AW'(1);
                    state_d    = ST_FETCH;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign out_dc   = (state_q == ST_PUSH);
    assign out_data = out_data_q;
    assign fb_addr  = byte_idx_q;

endmodule
